vram_arbiter: RTL and testbench

//  Time-slot arbiter sharing one single-port synchronous VRAM between the tile renderer's fetches
//  and CPU (Z180 bus bridge) reads/writes. A 16-pxclk slot wheel matches one 8-px tile at 2 pxclk/px.
//  - Video owns three fixed slots per tile: name, pattern, colour.
//  - The CPU gets every other slot.

---
 rtl/vram_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Time-slot arbiter sharing one single-port synchronous VRAM between the tile
// renderer and the CPU bus bridge. A 16-pxclk slot wheel covers one 8-px tile;
// video owns the name, pattern and colour slots while fetch_en_i is high, and
// the CPU gets every other slot.
//
// Optional feature: define VRAM_POSTED_WRITE_EN to add a one-entry posted write
// buffer. Writes are then acked the cycle after capture and drained at the
// first free CPU slot. Without the macro, writes follow the read path.
//
// Ports
//   pxclk, reset     clock, synchronous active-high reset
//   line_start_i     1-cycle pulse; the next cycle is slot 0
//   fetch_en_i       video slots reserved while high
//   vid_addr_i       renderer address for the phase on vid_phase_o
//   vid_phase_o      0 none, 1 name, 2 pattern, 3 colour (this cycle)
//   vid_rvalid_o     vid_rdata_o valid (cycle after a video slot)
//   vid_rtag_o       phase that produced vid_rdata_o
//   vid_rdata_o      VRAM read data pass-through
//   cpu_req_i        request, held until cpu_ack_o
//   cpu_we_i         1 write, 0 read
//   cpu_addr_i       CPU address
//   cpu_wdata_i      CPU write data
//   cpu_ack_o        1-cycle completion pulse
//   cpu_rdata_o      read data, valid with cpu_ack_o
//   ram_addr_o       VRAM address (holds last value in idle cycles)
//   ram_we_o         VRAM write enable
//   ram_wdata_o      VRAM write data
//   ram_rdata_i      VRAM read data, 1-cycle latency
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NAME_SLOT = 0,
    parameter int unsigned PAT_SLOT  = 4,
    parameter int unsigned COL_SLOT  = 8
) (
    input  logic              pxclk,
    input  logic              reset,
    input  logic              line_start_i,
    input  logic              fetch_en_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic [1:0]        vid_phase_o,
    output logic              vid_rvalid_o,
    output logic [1:0]        vid_rtag_o,
    output logic [DATA_W-1:0] vid_rdata_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int unsigned SLOT_W = 4;

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_NAME = 2'd1;
    localparam logic [1:0] PH_PAT  = 2'd2;
    localparam logic [1:0] PH_COL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } cpu_state_e;

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;
    logic [1:0]        phase_c;
    logic              vid_slot_c;

    cpu_state_e        state_q;
    logic              rd_pend_q;
    logic              cpu_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    logic              vid_rvalid_q;
    logic [1:0]        vid_rtag_q;

    logic [ADDR_W-1:0] ram_addr_q;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] ram_wdata_d;
    logic              ram_we_c;

    logic              issue_c;

    // Slot wheel: line_start wins over the increment
    always_comb begin
        slot_d = slot_q + SLOT_W'(1);
        if (line_start_i) begin
            slot_d = '0;
        end
    end

    // Video phase decode for the current slot
    always_comb begin
        phase_c = PH_NONE;
        if (fetch_en_i) begin
            if (slot_q == SLOT_W'(NAME_SLOT)) begin
                phase_c = PH_NAME;
            end else if (slot_q == SLOT_W'(PAT_SLOT)) begin
                phase_c = PH_PAT;
            end else if (slot_q == SLOT_W'(COL_SLOT)) begin
                phase_c = PH_COL;
            end
        end
    end

    assign vid_slot_c = (phase_c != PH_NONE);

`ifdef VRAM_POSTED_WRITE_EN
    logic              pb_valid_q;
    logic [ADDR_W-1:0] pb_addr_q;
    logic [DATA_W-1:0] pb_data_q;
    logic              drain_c;
    logic              capture_c;

    // A full buffer owns the next CPU slot, ahead of any new request
    assign drain_c   = pb_valid_q & ~vid_slot_c;
    // Capture needs no RAM slot; only an empty buffer at cycle start accepts
    assign capture_c = (state_q == ST_IDLE) & cpu_req_i & cpu_we_i & ~pb_valid_q;
    // Reads wait for the buffer to empty so read-after-write order holds
    assign issue_c   = (state_q == ST_IDLE) & cpu_req_i & ~cpu_we_i
                     & ~pb_valid_q & ~vid_slot_c;

    // Posted write buffer
    always_ff @(posedge pxclk) begin
        if (reset) begin
            pb_valid_q <= 1'b0;
            pb_addr_q  <= '0;
            pb_data_q  <= '0;
        end else if (capture_c) begin
            pb_valid_q <= 1'b1;
            pb_addr_q  <= cpu_addr_i;
            pb_data_q  <= cpu_wdata_i;
        end else if (drain_c) begin
            pb_valid_q <= 1'b0;
        end
    end
`else
    assign issue_c = (state_q == ST_IDLE) & cpu_req_i & ~vid_slot_c;
`endif

    // RAM port mux: video, then buffer drain, then CPU issue; else hold address
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_c    = 1'b0;
        if (vid_slot_c) begin
            ram_addr_d = vid_addr_i;
`ifdef VRAM_POSTED_WRITE_EN
        end else if (drain_c) begin
            ram_addr_d  = pb_addr_q;
            ram_wdata_d = pb_data_q;
            ram_we_c    = 1'b1;
`endif
        end else if (issue_c) begin
            ram_addr_d  = cpu_addr_i;
            ram_wdata_d = cpu_wdata_i;
            ram_we_c    = cpu_we_i;
        end
    end

    // Slot counter, video return tagging and held RAM address
    always_ff @(posedge pxclk) begin
        if (reset) begin
            slot_q       <= '0;
            vid_rvalid_q <= 1'b0;
            vid_rtag_q   <= PH_NONE;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            slot_q       <= slot_d;
            vid_rvalid_q <= vid_slot_c;
            vid_rtag_q   <= phase_c;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    // CPU transaction FSM: IDLE -> WAIT (RAM latency) -> ACK
    always_ff @(posedge pxclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_pend_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue_c) begin
                        state_q   <= ST_WAIT;
                        rd_pend_q <= ~cpu_we_i;
`ifdef VRAM_POSTED_WRITE_EN
                    end else if (capture_c) begin
                        state_q   <= ST_ACK;
                        cpu_ack_q <= 1'b1;
`endif
                    end
                end
                ST_WAIT: begin
                    if (rd_pend_q) begin
                        cpu_rdata_q <= ram_rdata_i;
                    end
                    state_q   <= ST_ACK;
                    cpu_ack_q <= 1'b1;
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Same-cycle RAM and phase outputs are held at zero while reset is asserted
    assign vid_phase_o  = reset ? PH_NONE : phase_c;
    assign ram_addr_o   = reset ? '0 : ram_addr_d;
    assign ram_wdata_o  = reset ? '0 : ram_wdata_d;
    assign ram_we_o     = ~reset & ram_we_c;

    assign vid_rvalid_o = vid_rvalid_q;
    assign vid_rtag_o   = vid_rtag_q;
    assign vid_rdata_o  = ram_rdata_i;
    assign cpu_ack_o    = cpu_ack_q;
    assign cpu_rdata_o  = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    logic        pxclk = 1'b0;
    logic        reset;
    logic        line_start;
    logic        fetch_en;
    logic [13:0] vid_addr;
    logic [1:0]  vid_phase;
    logic        vid_rvalid;
    logic [1:0]  vid_rtag;
    logic [7:0]  vid_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    always #5 pxclk = ~pxclk;

    vram_arbiter dut (
        .pxclk        (pxclk),
        .reset        (reset),
        .line_start_i (line_start),
        .fetch_en_i   (fetch_en),
        .vid_addr_i   (vid_addr),
        .vid_phase_o  (vid_phase),
        .vid_rvalid_o (vid_rvalid),
        .vid_rtag_o   (vid_rtag),
        .vid_rdata_o  (vid_rdata),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_ack_o    (cpu_ack),
        .cpu_rdata_o  (cpu_rdata),
        .ram_addr_o   (ram_addr),
        .ram_we_o     (ram_we),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata)
    );

`ifdef VRAM_POSTED_WRITE_EN
    localparam int WR_ACK_DLY = 1;
    localparam int RB_DLY     = 3;
`else
    localparam int WR_ACK_DLY = 2;
    localparam int RB_DLY     = 2;
`endif

    typedef struct {
        logic [1:0] tag;
        logic [7:0] data;
        int         due;
    } vid_exp_t;

    vid_exp_t   vid_q[$];
    logic [7:0] cpu_q[$];
    logic [7:0] ref_mem [0:16383];
    logic [7:0] mem     [0:16383];
    logic [7:0] last_rd;
    logic [3:0] tb_slot;
    logic       fe_cfg;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;

    function automatic logic [7:0] init_val(input logic [13:0] a);
        logic [7:0] v;
        v = 8'(a * 14'd37) ^ 8'(a >> 6);
        if (a == 14'h1234) v = 8'h5A;
        if (a == 14'h0100) v = 8'hC1;
        if (a == 14'h0800) v = 8'hC2;
        if (a == 14'h2000) v = 8'hC3;
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Single-port synchronous VRAM with one cycle of read latency
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = init_val(14'(i));
        ram_rdata = 8'h00;
        forever begin
            @(posedge pxclk);
            ram_rdata <= mem[ram_addr];
            if (ram_we) mem[ram_addr] = ram_wdata;
        end
    end

    always @(posedge pxclk) cyc <= cyc + 1;

    // Scoreboard: video returns and CPU completions
    always @(negedge pxclk) begin : mon
        vid_exp_t   e;
        logic [7:0] d;
        logic       exp_v;
        if (!reset) begin
            exp_v = (vid_q.size() > 0) && (vid_q[0].due == cyc);
            check_eq("vid_rvalid", 32'(vid_rvalid), 32'(exp_v));
            if (exp_v) begin
                e = vid_q.pop_front();
                check_eq("vid_rtag", 32'(vid_rtag), 32'(e.tag));
                check_eq("vid_rdata", 32'(vid_rdata), 32'(e.data));
            end
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    check_eq("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
                end else begin
                    d = cpu_q.pop_front();
                    check_eq("cpu_rdata", 32'(cpu_rdata), 32'(d));
                end
            end
        end
    end

    // Advance one pxclk; drive video addresses and check the video slot outputs
    task automatic next_cycle();
        logic [1:0] exp_ph;
        @(posedge pxclk);
        tb_slot = (line_start || reset) ? 4'd0 : tb_slot + 4'd1;
        #1;
        line_start = 1'b0;
        fetch_en   = fe_cfg;
        exp_ph     = 2'd0;
        if (fetch_en) begin
            case (tb_slot)
                4'd0:    exp_ph = 2'd1;
                4'd4:    exp_ph = 2'd2;
                4'd8:    exp_ph = 2'd3;
                default: exp_ph = 2'd0;
            endcase
        end
        case (exp_ph)
            2'd1:    vid_addr = 14'h0100;
            2'd2:    vid_addr = 14'h0800;
            2'd3:    vid_addr = 14'h2000;
            default: vid_addr = 14'($urandom);
        endcase
        if (exp_ph != 2'd0)
            vid_q.push_back('{tag: exp_ph, data: ref_mem[vid_addr], due: cyc + 1});
        #1;
        if (!reset) begin
            check_eq("vid_phase", 32'(vid_phase), 32'(exp_ph));
            if (exp_ph != 2'd0) begin
                check_eq("vid_ram_addr", 32'(ram_addr), 32'(vid_addr));
                check_eq("vid_ram_we", 32'(ram_we), 32'd0);
            end
        end
    endtask

    task automatic go_slot(input int n);
        line_start = 1'b1;
        next_cycle();
        repeat (n) next_cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_vid_phase"},  32'(vid_phase),  32'd0);
        check_eq({tag, "_vid_rvalid"}, 32'(vid_rvalid), 32'd0);
        check_eq({tag, "_vid_rtag"},   32'(vid_rtag),   32'd0);
        check_eq({tag, "_cpu_ack"},    32'(cpu_ack),    32'd0);
        check_eq({tag, "_cpu_rdata"},  32'(cpu_rdata),  32'd0);
        check_eq({tag, "_ram_addr"},   32'(ram_addr),   32'd0);
        check_eq({tag, "_ram_we"},     32'(ram_we),     32'd0);
        check_eq({tag, "_ram_wdata"},  32'(ram_wdata),  32'd0);
    endtask

    // Raise a CPU request in the current cycle; check the RAM port chk_dly cycles
    // later and the ack latency; the scoreboard checks the returned data.
    task automatic cpu_txn(input string tag, input logic we, input logic [13:0] a,
                           input logic [7:0] d, input int chk_dly, input logic [13:0] chk_addr,
                           input logic chk_we, input logic [7:0] chk_data, input int ack_dly);
        bit got;
        got       = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        if (we) begin
            ref_mem[a] = d;
        end else begin
            last_rd = ref_mem[a];
        end
        cpu_q.push_back(last_rd);
        for (int n = 0; n < 24 && !got; n++) begin
            if (n > 0) next_cycle();
            #1;
            if (n == chk_dly) begin
                check_eq({tag, "_ram_addr"}, 32'(ram_addr), 32'(chk_addr));
                check_eq({tag, "_ram_we"}, 32'(ram_we), 32'(chk_we));
                if (chk_we) check_eq({tag, "_ram_wdata"}, 32'(ram_wdata), 32'(chk_data));
            end
            @(negedge pxclk);
            if (cpu_ack) begin
                got = 1'b1;
                check_eq({tag, "_ack_latency"}, 32'(n), 32'(ack_dly));
            end
        end
        check_eq({tag, "_acked"}, 32'(got), 32'd1);
        cpu_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(14'(i));
        reset      = 1'b1;
        line_start = 1'b0;
        fe_cfg     = 1'b0;
        fetch_en   = 1'b0;
        vid_addr   = '0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        last_rd    = 8'h00;
        tb_slot    = 4'd0;

        repeat (3) next_cycle();
        check_all_zero("reset");
        reset = 1'b0;
        next_cycle();

        // Video fetches across one tile
        fe_cfg = 1'b1;
        go_slot(0);
        repeat (11) next_cycle();

        // CPU read in a free slot, ack lands on the pattern slot
        go_slot(2);
        cpu_txn("rd1234", 1'b0, 14'h1234, 8'h00, 0, 14'h1234, 1'b0, 8'h00, 2);
        next_cycle();

        // CPU write then readback
        go_slot(3);
`ifdef VRAM_POSTED_WRITE_EN
        cpu_txn("wr0010", 1'b1, 14'h0010, 8'hA5, -1, 14'h0000, 1'b0, 8'h00, WR_ACK_DLY);
`else
        cpu_txn("wr0010", 1'b1, 14'h0010, 8'hA5, 0, 14'h0010, 1'b1, 8'hA5, WR_ACK_DLY);
`endif
        next_cycle();
        cpu_txn("rb0010", 1'b0, 14'h0010, 8'h00, -1, 14'h0000, 1'b0, 8'h00, RB_DLY);
        next_cycle();

        // Request in a video slot is deferred one cycle; with fetch off it issues at once
        go_slot(8);
        cpu_txn("s8_fe1", 1'b0, 14'h3FFF, 8'h00, 1, 14'h3FFF, 1'b0, 8'h00, 3);
        fe_cfg = 1'b0;
        go_slot(8);
        cpu_txn("s8_fe0", 1'b0, 14'h0000, 8'h00, 0, 14'h0000, 1'b0, 8'h00, 2);
        fe_cfg = 1'b1;
        next_cycle();

        // line_start while the read is in WAIT: completes normally
        go_slot(14);
        line_start = 1'b1;
        cpu_txn("ls_wait", 1'b0, 14'h0123, 8'h00, 0, 14'h0123, 1'b0, 8'h00, 2);
        next_cycle();

        // Random transactions at random slots
        for (int k = 0; k < 8; k++) begin
            int         s;
            int         idly;
            logic       fe;
            logic       we;
            logic [13:0] a;
            logic [7:0]  d;
            s  = int'($urandom_range(0, 15));
            fe = 1'($urandom_range(0, 1));
`ifdef VRAM_POSTED_WRITE_EN
            we = 1'b0;
`else
            we = 1'($urandom_range(0, 1));
`endif
            a  = 14'($urandom) | 14'h0001;
            d  = 8'($urandom);
            fe_cfg = fe;
            go_slot(s);
            idly = (fe && (s == 0 || s == 4 || s == 8)) ? 1 : 0;
            cpu_txn("rnd", we, a, d, idly, a, we, d, idly + 2);
            next_cycle();
        end
        fe_cfg = 1'b1;

`ifdef VRAM_POSTED_WRITE_EN
        // Back-to-back posted writes; the second waits for the first to drain
        go_slot(3);
        cpu_txn("pw1", 1'b1, 14'h0001, 8'h11, -1, 14'h0000, 1'b0, 8'h00, 1);
        next_cycle();
        cpu_txn("pw2", 1'b1, 14'h0002, 8'h22, 0, 14'h0001, 1'b1, 8'h11, 2);
        next_cycle();
        cpu_txn("pr1", 1'b0, 14'h0001, 8'h00, 1, 14'h0001, 1'b0, 8'h00, 3);
        next_cycle();
        cpu_txn("pr2", 1'b0, 14'h0002, 8'h00, 0, 14'h0002, 1'b0, 8'h00, 2);
        next_cycle();
`endif

        // Reset in the middle of a read: no ack, everything cleared
        fe_cfg = 1'b0;
        go_slot(2);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 14'h0777;
        #1;
        check_eq("rst_issue_addr", 32'(ram_addr), 32'h0777);
        next_cycle();
        reset   = 1'b1;
        cpu_req = 1'b0;
        next_cycle();
        check_all_zero("rst_mid");
        reset   = 1'b0;
        last_rd = 8'h00;
        repeat (4) begin
            next_cycle();
            @(negedge pxclk);
            check_eq("rst_no_ack", 32'(cpu_ack), 32'd0);
        end

        repeat (3) next_cycle();
        check_eq("vid_q_drained", 32'(vid_q.size()), 32'd0);
        check_eq("cpu_q_drained", 32'(cpu_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
